// File: rtl/toy_pack.sv
// Shared sizing and state encoding for the rename recovery controller.
package toy_pack;

  localparam int unsigned ARCH_ENTRY_NUM   = 32;
  localparam int unsigned PHY_REG_ID_WIDTH = 8;
  localparam int unsigned ARCH_ID_WIDTH    = $clog2(ARCH_ENTRY_NUM);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StRestore,
    StDone
  } recov_state_e;

endpackage

// File: rtl/toy_rename_restore_lane_mux.sv
// Combinational indexed read of the committed int/fp mapping tables,
// one architectural entry per lane starting at idx.
module toy_rename_restore_lane_mux
  import toy_pack::*;
#(
  parameter int unsigned RESTORE_LANES = 4
) (
  input  logic [ARCH_ID_WIDTH-1:0]                         idx,
  input  logic [ARCH_ENTRY_NUM-1:0][PHY_REG_ID_WIDTH-1:0]  v_int_backup_phy_id,
  input  logic [ARCH_ENTRY_NUM-1:0][PHY_REG_ID_WIDTH-1:0]  v_fp_backup_phy_id,
  output logic [RESTORE_LANES-1:0][ARCH_ID_WIDTH-1:0]      v_lane_arch_id,
  output logic [RESTORE_LANES-1:0][PHY_REG_ID_WIDTH-1:0]   v_lane_int_phy_id,
  output logic [RESTORE_LANES-1:0][PHY_REG_ID_WIDTH-1:0]   v_lane_fp_phy_id
);

  always_comb begin
    v_lane_arch_id    = '0;
    v_lane_int_phy_id = '0;
    v_lane_fp_phy_id  = '0;
    for (int k = 0; k < int'(RESTORE_LANES); k++) begin
      // idx is always lane-aligned, so idx+k never wraps past the table end.
      v_lane_arch_id[k]    = idx + ARCH_ID_WIDTH'(k);
      v_lane_int_phy_id[k] = v_int_backup_phy_id[v_lane_arch_id[k]];
      v_lane_fp_phy_id[k]  = v_fp_backup_phy_id[v_lane_arch_id[k]];
    end
  end

endmodule

// File: rtl/toy_rename_recovery_ctrl.sv
// Flush recovery sequencer: waits for commit to go idle, copies the committed
// rename mapping back into the speculative table, then triggers a free list rebuild.
module toy_rename_recovery_ctrl
  import toy_pack::*;
#(
  parameter int unsigned RESTORE_LANES = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            flush_valid,
  input  logic                                            commit_idle,
  input  logic [ARCH_ENTRY_NUM-1:0][PHY_REG_ID_WIDTH-1:0] v_int_backup_phy_id,
  input  logic [ARCH_ENTRY_NUM-1:0][PHY_REG_ID_WIDTH-1:0] v_fp_backup_phy_id,
  output logic                                            rename_stall,
  output logic [RESTORE_LANES-1:0]                        v_restore_en,
  output logic [RESTORE_LANES-1:0][ARCH_ID_WIDTH-1:0]     v_restore_arch_id,
  output logic [RESTORE_LANES-1:0][PHY_REG_ID_WIDTH-1:0]  v_restore_int_phy_id,
  output logic [RESTORE_LANES-1:0][PHY_REG_ID_WIDTH-1:0]  v_restore_fp_phy_id,
  output logic                                            free_list_rebuild,
  output logic                                            recover_done
);

  if ((ARCH_ENTRY_NUM % RESTORE_LANES) != 0) begin : gen_lane_check
    $error("ARCH_ENTRY_NUM must be a multiple of RESTORE_LANES");
  end

  localparam logic [ARCH_ID_WIDTH-1:0] LastIdx = ARCH_ID_WIDTH'(ARCH_ENTRY_NUM - RESTORE_LANES);
  localparam logic [ARCH_ID_WIDTH-1:0] IdxStep = ARCH_ID_WIDTH'(RESTORE_LANES);

  recov_state_e             state_q, state_d;
  logic [ARCH_ID_WIDTH-1:0] idx_q, idx_d;
  logic                     restore_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    restore_active = 1'b0;
    case (state_q)
      StIdle: begin
        if (flush_valid) begin
          state_d = StDrain;
          idx_d   = '0;
        end
      end
      StDrain: begin
        if (flush_valid) begin
          idx_d = '0;
        end else if (commit_idle) begin
          state_d = StRestore;
        end
      end
      StRestore: begin
        if (commit_idle) begin
          restore_active = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + IdxStep;
          end
        end
        // A new flush overrides beat progress and restarts from entry 0.
        if (flush_valid) begin
          state_d = StDrain;
          idx_d   = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (flush_valid) begin
          state_d = StDrain;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  assign rename_stall      = (state_q != StIdle);
  assign v_restore_en      = {RESTORE_LANES{restore_active}};
  assign recover_done      = (state_q == StDone) && !flush_valid;
  assign free_list_rebuild = recover_done;

  toy_rename_restore_lane_mux #(
    .RESTORE_LANES(RESTORE_LANES)
  ) u_lane_mux (
    .idx                 (idx_q),
    .v_int_backup_phy_id (v_int_backup_phy_id),
    .v_fp_backup_phy_id  (v_fp_backup_phy_id),
    .v_lane_arch_id      (v_restore_arch_id),
    .v_lane_int_phy_id   (v_restore_int_phy_id),
    .v_lane_fp_phy_id    (v_restore_fp_phy_id)
  );

endmodule

// File: tb/tb_toy_rename_recovery_ctrl.sv
// Directed, table-driven bench for the rename recovery controller.
module tb_toy_rename_recovery_ctrl;
  import toy_pack::*;

  localparam int unsigned Lanes = 4;
  localparam int Beats = ARCH_ENTRY_NUM / Lanes;

  logic clk;
  logic rst_n;
  logic flush_valid;
  logic commit_idle;
  logic [ARCH_ENTRY_NUM-1:0][PHY_REG_ID_WIDTH-1:0] int_tbl;
  logic [ARCH_ENTRY_NUM-1:0][PHY_REG_ID_WIDTH-1:0] fp_tbl;
  logic                                           rename_stall;
  logic [Lanes-1:0]                               v_restore_en;
  logic [Lanes-1:0][ARCH_ID_WIDTH-1:0]            v_restore_arch_id;
  logic [Lanes-1:0][PHY_REG_ID_WIDTH-1:0]         v_restore_int_phy_id;
  logic [Lanes-1:0][PHY_REG_ID_WIDTH-1:0]         v_restore_fp_phy_id;
  logic                                           free_list_rebuild;
  logic                                           recover_done;

  toy_rename_recovery_ctrl #(
    .RESTORE_LANES(Lanes)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush_valid          (flush_valid),
    .commit_idle          (commit_idle),
    .v_int_backup_phy_id  (int_tbl),
    .v_fp_backup_phy_id   (fp_tbl),
    .rename_stall         (rename_stall),
    .v_restore_en         (v_restore_en),
    .v_restore_arch_id    (v_restore_arch_id),
    .v_restore_int_phy_id (v_restore_int_phy_id),
    .v_restore_fp_phy_id  (v_restore_fp_phy_id),
    .free_list_rebuild    (free_list_rebuild),
    .recover_done         (recover_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic flush;
    logic ci;
    logic stall;
    logic en;
    int   base;
    logic done;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passes = 0;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic f, input logic ci, input logic st, input logic en,
                     input int base, input logic dn);
    vec_t v;
    v.flush = f; v.ci = ci; v.stall = st; v.en = en; v.base = base; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic add_beats(input int first, input int last);
    for (int b = first; b <= last; b++) add(1'b0, 1'b1, 1'b1, 1'b1, b * int'(Lanes), 1'b0);
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs before the rising edge.
  task automatic check_cycle(input vec_t e, input int id);
    @(negedge clk);
    flush_valid = e.flush;
    commit_idle = e.ci;
    #1;
    cmp($sformatf("v%0d_stall", id), int'(rename_stall), int'(e.stall));
    cmp($sformatf("v%0d_en", id), int'(v_restore_en), e.en ? (1 << Lanes) - 1 : 0);
    cmp($sformatf("v%0d_done", id), int'(recover_done), int'(e.done));
    cmp($sformatf("v%0d_rebuild", id), int'(free_list_rebuild), int'(e.done));
    if (e.en) begin
      for (int k = 0; k < int'(Lanes); k++) begin
        cmp($sformatf("v%0d_arch%0d", id, k), int'(v_restore_arch_id[k]), e.base + k);
        cmp($sformatf("v%0d_int%0d", id, k), int'(v_restore_int_phy_id[k]), e.base + k + 40);
        cmp($sformatf("v%0d_fp%0d", id, k), int'(v_restore_fp_phy_id[k]), e.base + k + 100);
      end
    end
  endtask

  task automatic build_basic();
    add(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    add_beats(0, Beats - 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic run_basic_direct(input int tag);
    vec_t v;
    v.flush = 1'b1; v.ci = 1'b1; v.stall = 1'b0; v.en = 1'b0; v.base = 0; v.done = 1'b0;
    check_cycle(v, tag);
    v.flush = 1'b0; v.stall = 1'b1;
    check_cycle(v, tag + 1);
    v.en = 1'b1;
    for (int b = 0; b < Beats; b++) begin
      v.base = b * int'(Lanes);
      check_cycle(v, tag + 2 + b);
    end
    v.en = 1'b0; v.done = 1'b1;
    check_cycle(v, tag + 2 + Beats);
    v.done = 1'b0; v.stall = 1'b0;
    check_cycle(v, tag + 3 + Beats);
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < int'(ARCH_ENTRY_NUM); i++) begin
      int_tbl[i] = PHY_REG_ID_WIDTH'(i + 40);
      fp_tbl[i]  = PHY_REG_ID_WIDTH'(i + 100);
    end
    rst_n = 1'b0;
    flush_valid = 1'b0;
    commit_idle = 1'b1;
    repeat (2) @(negedge clk);
    cmp("rst_stall", int'(rename_stall), 0);
    cmp("rst_en", int'(v_restore_en), 0);
    cmp("rst_done", int'(recover_done), 0);
    cmp("rst_rebuild", int'(free_list_rebuild), 0);
    rst_n = 1'b1;

    // Basic back-to-back pass.
    build_basic();
    // Drain held by commit activity for five cycles.
    add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int c = 1; c <= 5; c++) add(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    add_beats(0, Beats - 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    // Two-cycle pause during beat 3.
    add(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    add_beats(0, 2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    add_beats(3, Beats - 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    // Re-flush during beat 5 restarts the whole pass.
    add(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    add_beats(0, 4);
    add(1'b1, 1'b1, 1'b1, 1'b1, 20, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    add_beats(0, Beats - 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    // Flush landing in DONE suppresses the pulses and restarts.
    add(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    add_beats(0, Beats - 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    add_beats(0, Beats - 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    foreach (vecs[i]) check_cycle(vecs[i], i);

    // Asynchronous reset during beat 4.
    v.flush = 1'b1; v.ci = 1'b1; v.stall = 1'b0; v.en = 1'b0; v.base = 0; v.done = 1'b0;
    check_cycle(v, 1000);
    v.flush = 1'b0; v.stall = 1'b1;
    check_cycle(v, 1001);
    v.en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      v.base = b * int'(Lanes);
      check_cycle(v, 1002 + b);
    end
    @(negedge clk);
    flush_valid = 1'b0;
    commit_idle = 1'b1;
    #1;
    cmp("pre_rst_en", int'(v_restore_en), (1 << Lanes) - 1);
    rst_n = 1'b0;
    #1;
    cmp("async_rst_stall", int'(rename_stall), 0);
    cmp("async_rst_en", int'(v_restore_en), 0);
    cmp("async_rst_done", int'(recover_done), 0);
    cmp("async_rst_rebuild", int'(free_list_rebuild), 0);
    @(negedge clk);
    cmp("held_rst_stall", int'(rename_stall), 0);
    cmp("held_rst_done", int'(recover_done), 0);
    rst_n = 1'b1;
    v.flush = 1'b0; v.ci = 1'b1; v.stall = 1'b0; v.en = 1'b0; v.base = 0; v.done = 1'b0;
    for (int c = 0; c < 12; c++) check_cycle(v, 1100 + c);
    run_basic_direct(1200);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
